// File: rtl/tape_player.sv
// Cassette playback engine: fetches bytes from a synchronous tape RAM and
// serialises each one as a framed square-wave bitstream on the cassette line.
module tape_player #(
   parameter int ADDR_W     = 16,
   parameter int HALF_ONE   = 1,
   parameter int HALF_ZERO  = 2,
   parameter int START_BITS = 1,
   parameter int STOP_BITS  = 2,
   parameter int MSB_FIRST  = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ce_tape,
   input  logic              loaded,
   input  logic [ADDR_W-1:0] length,
   input  logic              pause,
   input  logic              stop,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_data,
   output logic              req,
   output logic              out,
   output logic [ADDR_W-1:0] progress,
   output logic              done
);
   localparam int         FRAME_LEN  = START_BITS + 8 + STOP_BITS;
   localparam logic [3:0] LAST_BIT   = 4'(FRAME_LEN - 1);
   localparam logic [7:0] TICKS_ONE  = 8'(HALF_ONE);
   localparam logic [7:0] TICKS_ZERO = 8'(HALF_ZERO);

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_HIGH, S_LOW} state_t;

   state_t            r_state, w_next_state;
   logic [ADDR_W-1:0] r_length, r_mem_addr, r_progress;
   logic [13:0]       r_frame;
   logic [7:0]        r_tick;
   logic [3:0]        r_bit_cnt;
   logic              r_done;

   logic              w_tick, w_half_end, w_last_bit, w_more_bytes;
   logic [7:0]        w_half, w_data_ord;
   logic [13:0]       w_frame;

   assign w_tick       = ce_tape && !pause;
   assign w_half       = r_frame[0] ? TICKS_ONE : TICKS_ZERO;
   assign w_half_end   = w_tick && (r_tick == w_half - 8'd1);
   assign w_last_bit   = (r_bit_cnt == LAST_BIT);
   assign w_more_bytes = (({1'b0, r_progress} + (ADDR_W + 1)'(1)) < {1'b0, r_length});

   always_comb begin
      w_data_ord = mem_data;
      if (MSB_FIRST != 0) begin
         for (int i = 0; i < 8; i++) w_data_ord[i] = mem_data[7 - i];
      end
   end

   // Bit 0 is sent first; shifting in ones above the data leaves the stop bits in place.
   assign w_frame = {6'h3F, w_data_ord} << START_BITS;

   // NOTE: state is updated with non-blocking assignments so every process sees the pre-edge value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      // NOTE: hold-current default first, so no path through this block infers a latch.
      w_next_state = r_state;
      if (stop) begin
         w_next_state = S_IDLE;
      end else if (loaded) begin
         w_next_state = (length != '0) ? S_FETCH : S_IDLE;
      end else if (!pause) begin
         case (r_state)
            S_FETCH: w_next_state = S_LOAD;
            S_LOAD:  w_next_state = S_HIGH;
            S_HIGH:  if (w_half_end) w_next_state = S_LOW;
            S_LOW: begin
               if (w_half_end) begin
                  if (!w_last_bit)       w_next_state = S_HIGH;
                  else if (w_more_bytes) w_next_state = S_FETCH;
                  else                   w_next_state = S_IDLE;
               end
            end
            default: w_next_state = r_state;
         endcase
      end
   end

   always_comb begin
      out      = (r_state == S_HIGH);
      req      = (r_state != S_IDLE);
      mem_addr = r_mem_addr;
      progress = r_progress;
      done     = r_done;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_length   <= '0;
         r_mem_addr <= '0;
         r_progress <= '0;
         r_frame    <= '0;
         r_tick     <= '0;
         r_bit_cnt  <= '0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (stop) begin
            r_mem_addr <= '0;
            r_progress <= '0;
            r_tick     <= '0;
            r_bit_cnt  <= '0;
         end else if (loaded) begin
            r_length   <= length;
            r_mem_addr <= '0;
            r_progress <= '0;
            r_tick     <= '0;
            r_bit_cnt  <= '0;
            r_done     <= (length == '0);
         end else if (!pause) begin
            case (r_state)
               S_LOAD: begin
                  r_frame   <= w_frame;
                  r_tick    <= '0;
                  r_bit_cnt <= '0;
               end
               S_HIGH: begin
                  if (w_tick) r_tick <= w_half_end ? '0 : r_tick + 8'd1;
               end
               S_LOW: begin
                  if (w_tick) begin
                     if (!w_half_end) begin
                        r_tick <= r_tick + 8'd1;
                     end else begin
                        r_tick <= '0;
                        if (!w_last_bit) begin
                           r_frame   <= {1'b1, r_frame[13:1]};
                           r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_more_bytes) begin
                           r_progress <= r_progress + ADDR_W'(1);
                           r_mem_addr <= r_mem_addr + ADDR_W'(1);
                        end else begin
                           r_done <= 1'b1;
                        end
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_tape_player.sv
// Scoreboard bench for tape_player: a reference model expands each tape image into
// expected bits and frame totals; a monitor decodes the cassette waveform and compares.
module tb_tape_player;
   localparam int K_BIT  = 0;
   localparam int K_DONE = 1;

   typedef struct {
      int kind;
      int val;
      int idx;
   } sb_item_t;

   logic        clk, reset, ce_tape, loaded, pause, stop, sel;
   logic [15:0] length_d;
   logic        loaded_a, loaded_b, stop_a, stop_b;
   logic [15:0] mem_addr_a, progress_a;
   logic [7:0]  mem_addr_b, progress_b;
   logic [7:0]  mem_data_a, mem_data_b;
   logic        req_a, out_a, done_a, req_b, out_b, done_b;
   logic [7:0]  mem_a [256];
   logic [7:0]  mem_b [256];

   logic        out_m, req_m, done_m, stop_m, loaded_m;
   int          progress_m;

   sb_item_t    sb_q[$];
   int          total_checks = 0;
   int          bad_checks   = 0;
   bit          tick_rand    = 0;
   int          hc = 0, lc = 0, tot = 0, cap_prog = 0;
   bit          prev_done = 0;

   assign loaded_a   = loaded && !sel;
   assign loaded_b   = loaded && sel;
   assign stop_a     = stop && !sel;
   assign stop_b     = stop && sel;
   assign out_m      = sel ? out_b : out_a;
   assign req_m      = sel ? req_b : req_a;
   assign done_m     = sel ? done_b : done_a;
   assign stop_m     = sel ? stop_b : stop_a;
   assign loaded_m   = sel ? loaded_b : loaded_a;
   assign progress_m = sel ? int'(progress_b) : int'(progress_a);

   tape_player dut_a (
      .clk(clk), .reset(reset), .ce_tape(ce_tape), .loaded(loaded_a), .length(length_d),
      .pause(pause), .stop(stop_a), .mem_addr(mem_addr_a), .mem_data(mem_data_a),
      .req(req_a), .out(out_a), .progress(progress_a), .done(done_a)
   );

   tape_player #(.ADDR_W(8), .HALF_ONE(1), .HALF_ZERO(2), .START_BITS(0), .STOP_BITS(0), .MSB_FIRST(1)) dut_b (
      .clk(clk), .reset(reset), .ce_tape(ce_tape), .loaded(loaded_b), .length(length_d[7:0]),
      .pause(pause), .stop(stop_b), .mem_addr(mem_addr_b), .mem_data(mem_data_b),
      .req(req_b), .out(out_b), .progress(progress_b), .done(done_b)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      mem_data_a <= mem_a[mem_addr_a[7:0]];
      mem_data_b <= mem_b[mem_addr_b];
   end

   // Tape-rate tick: every 4 clks, or a random 3..6 clks apart.
   initial begin
      int tick_wait;
      ce_tape   = 0;
      tick_wait = 0;
      forever begin
         @(posedge clk); #1;
         if (tick_wait == 0) begin
            ce_tape   = 1;
            tick_wait = tick_rand ? int'($urandom_range(2, 5)) : 3;
         end else begin
            ce_tape   = 0;
            tick_wait = tick_wait - 1;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input int act, input int exp);
      total_checks++;
      if (act != exp) begin
         bad_checks++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: frame = start zeros, data in configured order, stop ones;
   // each bit lasts two halves of HALF_ONE or HALF_ZERO ticks.
   function automatic void model(input int len);
      int          st, sp, msb, h, t;
      logic [7:0]  d;
      int          bits[$];
      sb_item_t    it;
      st  = sel ? 0 : 1;
      sp  = sel ? 0 : 2;
      msb = sel ? 1 : 0;
      t   = 0;
      for (int b = 0; b < len; b++) begin
         d = sel ? mem_b[b] : mem_a[b];
         bits.delete();
         for (int i = 0; i < st; i++) bits.push_back(0);
         for (int i = 0; i < 8; i++) bits.push_back(msb ? int'(d[7 - i]) : int'(d[i]));
         for (int i = 0; i < sp; i++) bits.push_back(1);
         foreach (bits[i]) begin
            h = bits[i] ? 1 : 2;
            it.kind = K_BIT; it.val = h; it.idx = b;
            sb_q.push_back(it);
            t += 2 * h;
         end
      end
      it.kind = K_DONE; it.val = t; it.idx = 0;
      sb_q.push_back(it);
   endfunction

   task automatic emit_bit();
      sb_item_t it;
      if (sb_q.size() == 0) begin
         check("sb_underflow_bit", 1, 0);
      end else begin
         it = sb_q.pop_front();
         check("item_kind_bit", K_BIT, it.kind);
         check("bit_high_ticks", hc, it.val);
         check("bit_low_ticks", lc, it.val);
         check("bit_progress", cap_prog, it.idx);
      end
      hc = 0;
      lc = 0;
   endtask

   // Monitor: decodes high/low runs (in unpaused ticks) into bits.
   always @(negedge clk) begin
      sb_item_t it;
      if (prev_done) check("done_one_clk", int'(done_m), 0);
      prev_done = done_m;
      if (reset || stop_m || loaded_m) begin
         hc = 0; lc = 0; tot = 0;
      end else begin
         if (done_m) begin
            if (hc > 0) emit_bit();
            if (sb_q.size() == 0) begin
               check("sb_underflow_done", 1, 0);
            end else begin
               it = sb_q.pop_front();
               check("item_kind_done", it.kind, K_DONE);
               check("frame_total_ticks", tot, it.val);
            end
            check("req_at_done", int'(req_m), 0);
            check("out_at_done", int'(out_m), 0);
            tot = 0;
         end
         if (ce_tape && !pause && req_m) begin
            if (out_m) begin
               if (lc > 0) emit_bit();
               if (hc == 0) cap_prog = progress_m;
               hc++;
               tot++;
            end else if (hc > 0) begin
               lc++;
               tot++;
            end
         end
      end
   end

   task automatic start(input int len);
      @(posedge clk); #1;
      sb_q.delete();
      model(len);
      length_d = 16'(len);
      loaded   = 1;
      @(posedge clk); #1;
      loaded = 0;
   endtask

   task automatic wait_done(input int limit, input bit rand_pause);
      bit seen = 0;
      for (int i = 0; i < limit && !seen; i++) begin
         @(posedge clk); #1;
         if (rand_pause && out_m && $urandom_range(0, 5) == 0) pause = ~pause;
         @(negedge clk);
         if (done_m) seen = 1;
      end
      check("done_seen", int'(seen), 1);
      @(posedge clk); #1;
      pause = 0;
   endtask

   task automatic wait_edges(input int n, input bit rising, input int limit);
      int cnt = 0;
      bit prev = out_m;
      for (int i = 0; i < limit && cnt < n; i++) begin
         @(negedge clk);
         if (out_m != prev && out_m == rising) cnt++;
         prev = out_m;
      end
      check("edge_seen", cnt, n);
   endtask

   task automatic fill_random(input int n);
      for (int i = 0; i < n; i++) begin
         if (sel) mem_b[i] = 8'($urandom);
         else     mem_a[i] = 8'($urandom);
      end
   endtask

   initial begin
      int cnt, guard;
      reset = 1; loaded = 0; stop = 0; pause = 0; sel = 0; length_d = '0;
      for (int i = 0; i < 256; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
      repeat (3) @(negedge clk);
      check("rst_out_a", int'(out_a), 0);   check("rst_req_a", int'(req_a), 0);
      check("rst_done_a", int'(done_a), 0); check("rst_addr_a", int'(mem_addr_a), 0);
      check("rst_prog_a", int'(progress_a), 0);
      check("rst_out_b", int'(out_b), 0);   check("rst_req_b", int'(req_b), 0);
      @(posedge clk); #1;
      reset = 0;

      // Single byte 0x01 with default framing.
      mem_a[0] = 8'h01;
      start(1);
      wait_done(1000, 0);
      @(negedge clk);
      check("idle_req_after_done", int'(req_m), 0);
      check("idle_out_after_done", int'(out_m), 0);

      // Two bytes, back-to-back frames.
      mem_a[0] = 8'hFF; mem_a[1] = 8'h00;
      start(2);
      wait_done(1000, 0);

      // Pause for 100 ticks in the middle of the HIGH half of bit 3.
      mem_a[0] = 8'h01;
      start(1);
      wait_edges(4, 1, 600);
      guard = 0;
      while (!ce_tape && guard < 20) begin @(negedge clk); guard++; end
      @(posedge clk); #1;
      pause = 1;
      cnt = 0;
      for (int i = 0; i < 1000 && cnt < 100; i++) begin
         @(negedge clk);
         if (ce_tape) begin
            cnt++;
            check("pause_out_high", int'(out_m), 1);
            check("pause_req_high", int'(req_m), 1);
         end
      end
      @(posedge clk); #1;
      pause = 0;
      wait_done(1000, 0);

      // Stop mid-playback, then replay from byte 0.
      fill_random(3);
      start(3);
      repeat (250) @(posedge clk);
      #1;
      check("req_before_stop", int'(req_m), 1);
      stop = 1;
      sb_q.delete();
      @(posedge clk); #1;
      stop = 0;
      @(negedge clk);
      check("stop_out", int'(out_m), 0);
      check("stop_req", int'(req_m), 0);
      check("stop_progress", progress_m, 0);
      cnt = 0;
      repeat (60) begin @(negedge clk); if (done_m) cnt++; end
      check("no_done_after_stop", cnt, 0);
      fill_random(2);
      start(2);
      wait_done(1000, 0);

      // Zero-length image.
      start(0);
      @(negedge clk);
      check("len0_done", int'(done_m), 1);
      check("len0_req", int'(req_m), 0);
      repeat (3) begin
         @(negedge clk);
         check("len0_idle_req", int'(req_m), 0);
         check("len0_idle_out", int'(out_m), 0);
      end

      // Restart while active.
      fill_random(3);
      start(3);
      repeat (50) @(posedge clk);
      #1;
      fill_random(2);
      start(2);
      wait_done(1500, 0);

      // Randomised images, random tick spacing and pauses.
      tick_rand = 1;
      repeat (6) begin
         cnt = int'($urandom_range(1, 4));
         fill_random(cnt);
         start(cnt);
         wait_done(6000, 1);
      end
      sel = 1;
      repeat (3) begin
         cnt = int'($urandom_range(1, 3));
         fill_random(cnt);
         start(cnt);
         wait_done(4000, 1);
      end

      // Async reset in the middle of a LOW half, MSB-first unframed variant.
      tick_rand = 0;
      mem_b[0] = 8'h80;
      start(1);
      wait_edges(2, 0, 600);
      repeat (3) @(posedge clk);
      #3;
      check("req_before_reset", int'(req_m), 1);
      reset = 1;
      sb_q.delete();
      #1;
      check("arst_out", int'(out_b), 0);
      check("arst_req", int'(req_b), 0);
      check("arst_done", int'(done_b), 0);
      check("arst_addr", int'(mem_addr_b), 0);
      check("arst_prog", int'(progress_b), 0);
      @(posedge clk); #1;
      reset = 0;
      start(1);
      wait_done(1000, 0);

      repeat (5) @(posedge clk);
      check("sb_queue_empty", sb_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
      $finish;
   end
endmodule
